// File: rtl/spi_ram_arbiter.sv
// Two-port round-robin arbiter in front of the single SPI RAM controller.
// One word per transaction; strobes the controller, waits on busy, returns data.
module spi_ram_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_BITS      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_BITS-1:0]  a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_grant,
  output logic                  a_done,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_BITS-1:0]  b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_grant,
  output logic                  b_done,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_start_read,
  output logic                  ram_start_write,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  input  logic                  ram_busy,
  output logic                  timeout_err
);

  // state | meaning
  // IDLE  | arbitrate; latch winner's addr/wdata/we
  // ISSUE | one-cycle start strobe to the controller
  // ARM   | skip busy (it may lag the strobe); load watchdog
  // WAIT  | wait for busy low or watchdog terminal count
  // DONE  | one-cycle done pulse to the granted port
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_ARM,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TC_LOAD = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TC_ONE  = CNT_W'(1);

  state_e                state_q, state_d;
  logic                  last_b_q, last_b_d;
  logic                  sel_b_q, sel_b_d;
  logic                  op_we_q, op_we_d;
  logic                  a_grant_q, a_grant_d;
  logic                  b_grant_q, b_grant_d;
  logic                  a_done_q, a_done_d;
  logic                  b_done_q, b_done_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q, b_rdata_d;
  logic [ADDR_BITS-1:0]  ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic                  start_rd_q, start_rd_d;
  logic                  start_wr_q, start_wr_d;
  logic [CNT_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                  timeout_err_q, timeout_err_d;
  logic                  pick_b;
  logic                  pick_we;

  // On a tie the port that did not win last time goes next.
  assign pick_b  = b_req && !(a_req && last_b_q);
  assign pick_we = pick_b ? b_we : a_we;

  always_comb begin
    state_d       = state_q;
    last_b_d      = last_b_q;
    sel_b_d       = sel_b_q;
    op_we_d       = op_we_q;
    a_grant_d     = a_grant_q;
    b_grant_d     = b_grant_q;
    a_done_d      = 1'b0;
    b_done_d      = 1'b0;
    a_rdata_d     = a_rdata_q;
    b_rdata_d     = b_rdata_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    start_rd_d    = 1'b0;
    start_wr_d    = 1'b0;
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if (a_req || b_req) begin
          sel_b_d       = pick_b;
          last_b_d      = pick_b;
          op_we_d       = pick_we;
          ram_addr_d    = pick_b ? b_addr : a_addr;
          ram_data_in_d = pick_b ? b_wdata : a_wdata;
          a_grant_d     = !pick_b;
          b_grant_d     = pick_b;
          start_wr_d    = pick_we;
          start_rd_d    = !pick_we;
          state_d       = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_ARM;
      ST_ARM: begin
        wd_cnt_d = TC_LOAD;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (!ram_busy) begin
          if (!op_we_q) begin
            if (sel_b_q) b_rdata_d = ram_data_out;
            else         a_rdata_d = ram_data_out;
          end
          a_done_d = !sel_b_q;
          b_done_d = sel_b_q;
          state_d  = ST_DONE;
        end else if (TIMEOUT_CYCLES != 0) begin
          if (wd_cnt_q == TC_ONE) begin
            timeout_err_d = 1'b1;
            a_done_d      = !sel_b_q;
            b_done_d      = sel_b_q;
            state_d       = ST_DONE;
          end else begin
            wd_cnt_d = wd_cnt_q - TC_ONE;
          end
        end
      end
      ST_DONE: begin
        a_grant_d = 1'b0;
        b_grant_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_b_q      <= 1'b1;
      sel_b_q       <= 1'b0;
      op_we_q       <= 1'b0;
      a_grant_q     <= 1'b0;
      b_grant_q     <= 1'b0;
      a_done_q      <= 1'b0;
      b_done_q      <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      start_rd_q    <= 1'b0;
      start_wr_q    <= 1'b0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_b_q      <= last_b_d;
      sel_b_q       <= sel_b_d;
      op_we_q       <= op_we_d;
      a_grant_q     <= a_grant_d;
      b_grant_q     <= b_grant_d;
      a_done_q      <= a_done_d;
      b_done_q      <= b_done_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      start_rd_q    <= start_rd_d;
      start_wr_q    <= start_wr_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign a_grant         = a_grant_q;
  assign b_grant         = b_grant_q;
  assign a_done          = a_done_q;
  assign b_done          = b_done_q;
  assign a_rdata         = a_rdata_q;
  assign b_rdata         = b_rdata_q;
  assign ram_addr        = ram_addr_q;
  assign ram_data_in     = ram_data_in_q;
  assign ram_start_read  = start_rd_q;
  assign ram_start_write = start_wr_q;
  assign timeout_err     = timeout_err_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: transaction-level model plus directed vectors,
// a second instance with a short watchdog, and a randomized two-port phase.
module tb_spi_ram_arbiter;
  localparam int DW = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic a_grant, a_done, b_grant, b_done;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in, ram_data_out;
  logic ram_start_read, ram_start_write, ram_busy, timeout_err;

  logic w_a_req, w_b_req, w_busy;
  logic [DW-1:0] w_rdo;
  logic w_a_grant, w_a_done, w_b_grant, w_b_done;
  logic [DW-1:0] w_a_rdata, w_b_rdata, w_ram_data_in;
  logic [AW-1:0] w_ram_addr;
  logic w_start_rd, w_start_wr, w_timeout_err;

  spi_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .TIMEOUT_CYCLES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_grant(a_grant), .a_done(a_done), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_grant(b_grant), .b_done(b_done), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_start_read(ram_start_read), .ram_start_write(ram_start_write),
    .ram_data_out(ram_data_out), .ram_busy(ram_busy), .timeout_err(timeout_err)
  );

  spi_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_BITS(AW), .TIMEOUT_CYCLES(8)) dut_wd (
    .clk(clk), .rst_n(rst_n),
    .a_req(w_a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_grant(w_a_grant), .a_done(w_a_done), .a_rdata(w_a_rdata),
    .b_req(w_b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_grant(w_b_grant), .b_done(w_b_done), .b_rdata(w_b_rdata),
    .ram_addr(w_ram_addr), .ram_data_in(w_ram_data_in),
    .ram_start_read(w_start_rd), .ram_start_write(w_start_wr),
    .ram_data_out(w_rdo), .ram_busy(w_busy), .timeout_err(w_timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference model and controller model (negedge process)
  bit            model_free, last_b, exp_b, exp_we, issue_due, was_free, rnd_mode;
  logic [AW-1:0] exp_addr, obs_addr;
  logic [DW-1:0] exp_wdata, obs_wdata, exp_ard, exp_brd, cur_data, cont_data;
  int            busy_left, cont_len;
  int            n_rd_strobe, n_wr_strobe, n_a_done, n_b_done;
  int            obs_q[$];
  bit            a_done_seen, b_done_seen;

  initial begin
    model_free = 1; last_b = 1; issue_due = 0; rnd_mode = 0;
    exp_ard = '0; exp_brd = '0; busy_left = 0; cont_len = 0; cont_data = '0; cur_data = '0;
    n_rd_strobe = 0; n_wr_strobe = 0; n_a_done = 0; n_b_done = 0;
    exp_b = 0; exp_we = 0; exp_addr = '0; exp_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_free = 1; last_b = 1; issue_due = 0; exp_ard = '0; exp_brd = '0;
        ram_busy = 1'b0; busy_left = 0; a_done_seen = 0; b_done_seen = 0;
        continue;
      end
      was_free = model_free;
      check("a_grant", a_grant, !model_free && !exp_b);
      check("b_grant", b_grant, !model_free && exp_b);
      if (issue_due) begin
        check("start_read", ram_start_read, !exp_we);
        check("start_write", ram_start_write, exp_we);
        check("ram_addr", ram_addr, exp_addr);
        check("ram_data_in", ram_data_in, exp_wdata);
        obs_q.push_back(b_grant ? 1 : 0);
        obs_addr = ram_addr;
        obs_wdata = ram_data_in;
        issue_due = 0;
      end else begin
        check("no_strobe", {ram_start_read, ram_start_write}, 0);
      end
      n_rd_strobe += int'(ram_start_read);
      n_wr_strobe += int'(ram_start_write);
      // controller: busy for cont_len cycles starting mid-ISSUE, data valid when busy drops
      if (ram_start_read || ram_start_write) begin
        if (rnd_mode) begin
          cont_len  = $urandom_range(0, 6);
          cont_data = DW'($urandom);
        end
        cur_data  = cont_data;
        busy_left = cont_len;
        ram_busy  = (cont_len > 0);
        ram_data_out = (cont_len > 0) ? DW'($urandom) : cur_data;
      end else if (ram_busy) begin
        busy_left--;
        if (busy_left == 0) begin
          ram_busy = 1'b0;
          ram_data_out = cur_data;
        end
      end
      a_done_seen = a_done;
      b_done_seen = b_done;
      check("one_done", a_done && b_done, 0);
      if (a_done || b_done) begin
        check("done_port", b_done, exp_b);
        check("done_in_flight", model_free, 0);
        if (!exp_we) begin
          if (exp_b) exp_brd = cur_data;
          else       exp_ard = cur_data;
        end
        n_a_done += int'(a_done);
        n_b_done += int'(b_done);
        model_free = 1;
      end
      check("a_rdata", a_rdata, exp_ard);
      check("b_rdata", b_rdata, exp_brd);
      check("timeout_err", timeout_err, 0);
      if (was_free && (a_req || b_req)) begin
        if (a_req && b_req) exp_b = !last_b;
        else                exp_b = b_req;
        last_b    = exp_b;
        exp_we    = exp_b ? b_we : a_we;
        exp_addr  = exp_b ? b_addr : a_addr;
        exp_wdata = exp_b ? b_wdata : a_wdata;
        model_free = 0;
        issue_due  = 1;
      end
    end
  end

  typedef struct {
    bit            port_b;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            busy_len;
    logic [DW-1:0] ret;
    int            lat;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input vec_t v, output int lat);
    @(posedge clk); #1;
    cont_len  = v.busy_len;
    cont_data = v.ret;
    if (v.port_b) begin
      b_we = v.we; b_addr = v.addr; b_wdata = v.wdata; b_req = 1'b1;
    end else begin
      a_we = v.we; a_addr = v.addr; a_wdata = v.wdata; a_req = 1'b1;
    end
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (v.port_b ? b_done : a_done) begin
        lat = c;
        break;
      end
    end
    @(posedge clk); #1;
    a_req = 1'b0; b_req = 1'b0;
  endtask

  int  lat, rd0, wr0, k, nd;
  bit  found;

  initial begin
    // done latency = 4 + max(0, busy_len - 2) with this controller model
    vecs[0] = '{0, 0, 16'h0012, 16'h0000, 20, 16'hBEEF, 22, 16'hBEEF};
    vecs[1] = '{1, 1, 16'h8000, 16'h1234,  5, 16'h0000,  7, 16'h0000};
    vecs[2] = '{0, 0, 16'hFFFF, 16'h9999,  0, 16'h0001,  4, 16'h0001};
    vecs[3] = '{1, 0, 16'h0000, 16'h0000,  3, 16'hA5A5,  5, 16'hA5A5};
    vecs[4] = '{0, 1, 16'h00FF, 16'hFFFF,  1, 16'h0000,  4, 16'h0001};
    vecs[5] = '{1, 0, 16'h1234, 16'h0000,  2, 16'hCAFE,  4, 16'hCAFE};

    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    w_a_req = 0; w_b_req = 0; w_busy = 0; w_rdo = '0;
    ram_busy = 0; ram_data_out = '0;

    // both ports requesting from reset: strict A,B,A,B
    a_we = 0; a_addr = 16'h0100;
    b_we = 1; b_addr = 16'h0200; b_wdata = 16'h5555;
    a_req = 1; b_req = 1;
    cont_len = 1; cont_data = 16'h1111;
    @(negedge clk);
    check("reset_ctrl", {a_grant, b_grant, a_done, b_done, ram_start_read, ram_start_write, timeout_err}, 0);
    check("reset_data", {a_rdata, b_rdata, ram_addr, ram_data_in} == '0, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 100 && nd < 4; c++) begin
      @(negedge clk);
      nd += int'(a_done) + int'(b_done);
    end
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    check("fair_count", obs_q.size(), 4);
    if (obs_q.size() >= 4) begin
      check("fair_0", obs_q[0], 0);
      check("fair_1", obs_q[1], 1);
      check("fair_2", obs_q[2], 0);
      check("fair_3", obs_q[3], 1);
    end
    check("fair_a_dones", n_a_done, 2);
    check("fair_b_dones", n_b_done, 2);
    repeat (2) @(posedge clk);
    #1;

    // table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      rd0 = n_rd_strobe; wr0 = n_wr_strobe;
      run_txn(vecs[i], lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_rdata", i), vecs[i].port_b ? b_rdata : a_rdata, vecs[i].exp_rdata);
      check($sformatf("v%0d_rd_strobes", i), n_rd_strobe - rd0, int'(!vecs[i].we));
      check($sformatf("v%0d_wr_strobes", i), n_wr_strobe - wr0, int'(vecs[i].we));
      check($sformatf("v%0d_addr", i), obs_addr, vecs[i].addr);
      if (vecs[i].we) check($sformatf("v%0d_wdata", i), obs_wdata, vecs[i].wdata);
    end

    // fields changed mid-transaction are ignored until the next grant
    @(posedge clk); #1;
    a_we = 0; a_addr = 16'h0001; a_req = 1; cont_len = 10; cont_data = 16'h7777;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = ram_start_read;
    end
    check("t4_strobe_seen", found, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_addr = 16'h0002; a_wdata = 16'hDEAD; a_we = 1;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      check("t4_addr_held", ram_addr, 16'h0001);
      found = a_done;
    end
    check("t4_done_seen", found, 1);
    cont_len = 2;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = ram_start_write;
    end
    check("t4_second_strobe", found, 1);
    check("t4_new_addr", ram_addr, 16'h0002);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = a_done;
    end
    check("t4_second_done", found, 1);
    @(posedge clk); #1;
    a_req = 0; a_we = 0; a_wdata = '0;

    // watchdog on the short-timeout instance: busy stuck high
    a_addr = 16'h0042; w_busy = 1; w_a_req = 1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = w_start_rd;
    end
    check("wd_strobe_seen", found, 1);
    k = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (w_a_done) begin
        k = c;
        break;
      end
    end
    check("wd_latency", k, 10);
    check("wd_grant_in_done", w_a_grant, 1);
    check("wd_timeout_set", w_timeout_err, 1);
    check("wd_rdata_kept", w_a_rdata, 0);
    @(posedge clk); #1;
    w_a_req = 0; w_busy = 0; w_rdo = 16'h5A5A;
    repeat (3) @(posedge clk);
    #1;
    check("wd_sticky", w_timeout_err, 1);
    w_a_req = 1;
    k = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (w_a_done) begin
        k = c;
        break;
      end
    end
    check("wd_next_latency", k, 4);
    @(posedge clk); #1;
    w_a_req = 0;
    check("wd_next_rdata", w_a_rdata, 16'h5A5A);
    check("wd_sticky_after", w_timeout_err, 1);
    check("wd_port_b_quiet", {w_b_grant, w_b_done, w_b_rdata, w_start_wr}, 0);
    check("wd_addr_data", {w_ram_addr, w_ram_data_in}, {16'h0042, 16'h0000});

    // randomized two-port traffic against the model
    rnd_mode = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      if (a_req && a_done_seen) a_req = 1'($urandom_range(0, 1));
      else if (!a_req)          a_req = ($urandom_range(0, 2) == 0);
      if (b_req && b_done_seen) b_req = 1'($urandom_range(0, 1));
      else if (!b_req)          b_req = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 2) == 0) begin
        a_we = 1'($urandom); a_addr = AW'($urandom); a_wdata = DW'($urandom);
      end
      if ($urandom_range(0, 2) == 0) begin
        b_we = 1'($urandom); b_addr = AW'($urandom); b_wdata = DW'($urandom);
      end
    end
    for (int c = 0; c < 200 && (a_req || b_req); c++) begin
      @(posedge clk); #1;
      if (a_req && a_done_seen) a_req = 0;
      if (b_req && b_done_seen) b_req = 0;
    end
    check("rnd_drained", {a_req, b_req}, 0);
    rnd_mode = 0;
    check("rnd_activity", (n_a_done > 10) && (n_b_done > 10), 1);

    // async reset during WAIT, then A wins the first tie
    repeat (4) @(posedge clk);
    #1;
    a_we = 0; a_addr = 16'h0033; a_req = 1; cont_len = 10; cont_data = 16'h3333;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = ram_start_read;
    end
    check("t6_strobe_seen", found, 1);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_ctrl_zero", {a_grant, b_grant, a_done, b_done, ram_start_read, ram_start_write, timeout_err}, 0);
    check("t6_rdata_zero", {a_rdata, b_rdata}, 0);
    check("t6_ram_zero", {ram_addr, ram_data_in}, 0);
    b_we = 0; b_addr = 16'h0044; b_req = 1; cont_len = 2;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      found = ram_start_read;
    end
    check("t6_first_grant_seen", found, 1);
    check("t6_a_wins", {a_grant, b_grant}, 2'b10);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = a_done;
    end
    check("t6_a_done", found, 1);
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    repeat (4) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
